// File: rtl/grain128a.sv
// ---------------------------------------------------------------------------
// grain128a -- bit-serial Grain-128a pre-output generator.
//
// A pulse on INIT_I (on an enabled edge) restarts the core. The next 128
// enabled edges shift in the key (first bit = k0) and the IV (first bit =
// IV0; IV_I is ignored after 96 bits). 256 warm-up rounds follow, with the
// pre-output fed back into both registers. After that, every enabled edge
// produces one keystream bit.
//
// Ports:
//   CLK_I             in   clock, rising edge
//   ARESET_I          in   asynchronous active-low reset, clears all state
//   CLKEN_I           in   clock enable; no state changes when 0
//   KEY_I             in   serial key bit
//   IV_I              in   serial IV bit
//   INIT_I            in   start/restart load (sampled when CLKEN_I=1)
//   KEYSTREAM_O       out  pre-output bit y of current state, 0 when invalid
//   KEYSTREAM_VALID_O out  KEYSTREAM_O carries a keystream bit
//
// Optional build macro: GRAIN128A_AUTH_MODE_EN
//   When defined and the loaded IV0 is 1, the first 64 RUN bits are
//   suppressed and only every second bit after that (y64, y66, ...) is
//   flagged valid. When IV0 is 0, or the macro is undefined, every RUN bit
//   is valid.
// ---------------------------------------------------------------------------
module grain128a (
    input  logic CLK_I,
    input  logic ARESET_I,
    input  logic CLKEN_I,
    input  logic KEY_I,
    input  logic IV_I,
    input  logic INIT_I,
    output logic KEYSTREAM_O,
    output logic KEYSTREAM_VALID_O
);

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_LOAD   = 2'd1,
        PH_WARMUP = 2'd2,
        PH_RUN    = 2'd3
    } phase_e;

    phase_e       phase_q, phase_d;
    logic [7:0]   cnt_q, cnt_d;
    // Bit i of lfsr_q is s_i, bit i of nfsr_q is b_i.
    logic [127:0] lfsr_q, lfsr_d;
    logic [127:0] nfsr_q, nfsr_d;

    logic h_bit, y_bit, f_bit, g_bit;
    logic load_s_bit;
    logic run_valid;

`ifdef GRAIN128A_AUTH_MODE_EN
    // auth_q: IV0 latched during load. skip_q counts the 64 suppressed RUN
    // bits and saturates at 64 (bit 6 set); par_q then selects the
    // even-indexed bits.
    logic       auth_q, auth_d;
    logic [6:0] skip_q, skip_d;
    logic       par_q, par_d;
`endif

    // -----------------------------------------------------------------------
    // Grain-128a Boolean functions on the current state.
    // -----------------------------------------------------------------------
    always_comb begin
        h_bit = (nfsr_q[12] & lfsr_q[8])
              ^ (lfsr_q[13] & lfsr_q[20])
              ^ (nfsr_q[95] & lfsr_q[42])
              ^ (lfsr_q[60] & lfsr_q[79])
              ^ (nfsr_q[12] & nfsr_q[95] & lfsr_q[94]);

        y_bit = h_bit ^ lfsr_q[93]
              ^ nfsr_q[2]  ^ nfsr_q[15] ^ nfsr_q[36] ^ nfsr_q[45]
              ^ nfsr_q[64] ^ nfsr_q[73] ^ nfsr_q[89];

        f_bit = lfsr_q[0] ^ lfsr_q[7] ^ lfsr_q[38]
              ^ lfsr_q[70] ^ lfsr_q[81] ^ lfsr_q[96];

        g_bit = lfsr_q[0]
              ^ nfsr_q[0] ^ nfsr_q[26] ^ nfsr_q[56] ^ nfsr_q[91] ^ nfsr_q[96]
              ^ (nfsr_q[3]  & nfsr_q[67])
              ^ (nfsr_q[11] & nfsr_q[13])
              ^ (nfsr_q[17] & nfsr_q[18])
              ^ (nfsr_q[27] & nfsr_q[59])
              ^ (nfsr_q[40] & nfsr_q[48])
              ^ (nfsr_q[61] & nfsr_q[65])
              ^ (nfsr_q[68] & nfsr_q[84])
              ^ (nfsr_q[88] & nfsr_q[92] & nfsr_q[93] & nfsr_q[95])
              ^ (nfsr_q[22] & nfsr_q[24] & nfsr_q[25])
              ^ (nfsr_q[70] & nfsr_q[78] & nfsr_q[82]);
    end

    // Loading shifts in at index 127 and moves down, so the bit taken on
    // load edge n ends up at index n after all 128 edges. For the LFSR the
    // tail after the IV is the fixed padding: ones, then a final zero.
    assign load_s_bit = (cnt_q < 8'd96) ? IV_I : (cnt_q != 8'd127);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        nfsr_d  = nfsr_q;
`ifdef GRAIN128A_AUTH_MODE_EN
        auth_d  = auth_q;
        skip_d  = skip_q;
        par_d   = par_q;
`endif
        if (INIT_I) begin
            // Restart from any phase; KEY_I/IV_I on this edge are dropped.
            phase_d = PH_LOAD;
            cnt_d   = 8'd0;
`ifdef GRAIN128A_AUTH_MODE_EN
            auth_d  = 1'b0;
            skip_d  = 7'd0;
            par_d   = 1'b0;
`endif
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    // Wait for INIT_I.
                end
                PH_LOAD: begin
                    lfsr_d = {load_s_bit, lfsr_q[127:1]};
                    nfsr_d = {KEY_I, nfsr_q[127:1]};
`ifdef GRAIN128A_AUTH_MODE_EN
                    if (cnt_q == 8'd0) begin
                        auth_d = IV_I;
                    end
`endif
                    if (cnt_q == 8'd127) begin
                        cnt_d   = 8'd0;
                        phase_d = PH_WARMUP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                PH_WARMUP: begin
                    // Pre-output is fed back into both registers.
                    lfsr_d = {f_bit ^ y_bit, lfsr_q[127:1]};
                    nfsr_d = {g_bit ^ y_bit, nfsr_q[127:1]};
                    cnt_d  = cnt_q + 8'd1;
                    // The 8-bit counter wrapping 255 -> 0 ends warm-up.
                    if (cnt_q == 8'd255) begin
                        phase_d = PH_RUN;
                    end
                end
                PH_RUN: begin
                    lfsr_d = {f_bit, lfsr_q[127:1]};
                    nfsr_d = {g_bit, nfsr_q[127:1]};
`ifdef GRAIN128A_AUTH_MODE_EN
                    if (!skip_q[6]) begin
                        skip_d = skip_q + 7'd1;
                    end else begin
                        par_d = ~par_q;
                    end
`endif
                end
                default: begin
                    phase_d = PH_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_I or negedge ARESET_I) begin
        if (!ARESET_I) begin
            phase_q <= PH_IDLE;
            cnt_q   <= 8'd0;
            lfsr_q  <= '0;
            nfsr_q  <= '0;
`ifdef GRAIN128A_AUTH_MODE_EN
            auth_q  <= 1'b0;
            skip_q  <= 7'd0;
            par_q   <= 1'b0;
`endif
        end else if (CLKEN_I) begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            nfsr_q  <= nfsr_d;
`ifdef GRAIN128A_AUTH_MODE_EN
            auth_q  <= auth_d;
            skip_q  <= skip_d;
            par_q   <= par_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from registered state only, so the bit holds while
    // CLKEN_I is low.
    // -----------------------------------------------------------------------
`ifdef GRAIN128A_AUTH_MODE_EN
    assign run_valid = (phase_q == PH_RUN) && (!auth_q || (skip_q[6] && !par_q));
`else
    assign run_valid = (phase_q == PH_RUN);
`endif

    assign KEYSTREAM_VALID_O = run_valid;
    assign KEYSTREAM_O       = run_valid & y_bit;

endmodule

// File: tb/tb_grain128a.sv
// ---------------------------------------------------------------------------
// tb_grain128a -- self-checking bench for the grain128a core (default build,
// authentication macro undefined).
// ---------------------------------------------------------------------------
module tb_grain128a;

    logic CLK_I = 1'b0;
    logic ARESET_I;
    logic CLKEN_I;
    logic KEY_I;
    logic IV_I;
    logic INIT_I;
    logic KEYSTREAM_O;
    logic KEYSTREAM_VALID_O;

    int n_vec = 0;
    int n_err = 0;

    grain128a dut (
        .CLK_I             (CLK_I),
        .ARESET_I          (ARESET_I),
        .CLKEN_I           (CLKEN_I),
        .KEY_I             (KEY_I),
        .IV_I              (IV_I),
        .INIT_I            (INIT_I),
        .KEYSTREAM_O       (KEYSTREAM_O),
        .KEYSTREAM_VALID_O (KEYSTREAM_VALID_O)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct {
        logic [127:0] key;
        logic [95:0]  iv;
        logic [127:0] ks;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    // Reference model: algorithm-level Grain-128a on bit arrays. Key bit k_n
    // is key[127-n], IV bit IV_n is iv[95-n], keystream y_i goes to ks[127-i].
    function automatic logic [127:0] model_ks(input logic [127:0] key, input logic [95:0] iv);
        bit s[128];
        bit b[128];
        bit h, y, f, g;
        logic [127:0] ks;
        ks = '0;
        for (int i = 0; i < 128; i++) begin
            b[i] = key[127-i];
            s[i] = (i < 96) ? iv[95-i] : (i != 127);
        end
        for (int t = 0; t < 256 + 128; t++) begin
            h = (b[12] & s[8]) ^ (s[13] & s[20]) ^ (b[95] & s[42]) ^ (s[60] & s[79]) ^ (b[12] & b[95] & s[94]);
            y = h ^ s[93] ^ b[2] ^ b[15] ^ b[36] ^ b[45] ^ b[64] ^ b[73] ^ b[89];
            f = s[0] ^ s[7] ^ s[38] ^ s[70] ^ s[81] ^ s[96];
            g = s[0] ^ b[0] ^ b[26] ^ b[56] ^ b[91] ^ b[96] ^ (b[3] & b[67]) ^ (b[11] & b[13])
              ^ (b[17] & b[18]) ^ (b[27] & b[59]) ^ (b[40] & b[48]) ^ (b[61] & b[65]) ^ (b[68] & b[84])
              ^ (b[88] & b[92] & b[93] & b[95]) ^ (b[22] & b[24] & b[25]) ^ (b[70] & b[78] & b[82]);
            if (t >= 256) ks[127-(t-256)] = y;
            for (int i = 0; i < 127; i++) begin
                s[i] = s[i+1];
                b[i] = b[i+1];
            end
            s[127] = (t < 256) ? (f ^ y) : f;
            b[127] = (t < 256) ? (g ^ y) : g;
        end
        return ks;
    endfunction

    // Full sequence: INIT edge, 128 load edges, 256 warm-up edges, then 128
    // collected keystream bits, all with random CLKEN. Also records VALID
    // before edge 385, VALID missing afterwards, and output changes across
    // disabled cycles.
    task automatic run_seq(input logic [127:0] key, input logic [95:0] iv, output logic [127:0] ks,
                           output int early_valid, output int late_invalid, output int hold_err,
                           output int timeout);
        int  en_edges;
        int  got;
        int  cyc;
        int  n;
        logic prev_bit;
        logic prev_en;
        ks = '0;
        early_valid = 0;
        late_invalid = 0;
        hold_err = 0;
        timeout = 0;
        CLKEN_I = 1'b1;
        INIT_I  = 1'b1;
        KEY_I   = 1'($urandom_range(0, 1));
        IV_I    = 1'($urandom_range(0, 1));
        tick();
        INIT_I  = 1'b0;
        en_edges = 1;
        cyc = 0;
        while (en_edges < 385 && cyc < 4000) begin
            if (KEYSTREAM_VALID_O !== 1'b0) early_valid++;
            CLKEN_I = ($urandom_range(0, 3) != 0);
            n = en_edges - 1;
            KEY_I = (n < 128) ? key[127-n] : 1'($urandom_range(0, 1));
            IV_I  = (n < 96)  ? iv[95-n]   : 1'($urandom_range(0, 1));
            tick();
            cyc++;
            if (CLKEN_I) en_edges++;
        end
        if (cyc >= 4000) timeout++;
        got = 0;
        cyc = 0;
        prev_en = 1'b1;
        prev_bit = 1'b0;
        while (got < 128 && cyc < 4000) begin
            if (KEYSTREAM_VALID_O !== 1'b1) late_invalid++;
            if (!prev_en && KEYSTREAM_O !== prev_bit) hold_err++;
            prev_bit = KEYSTREAM_O;
            CLKEN_I = ($urandom_range(0, 3) != 0);
            if (CLKEN_I) begin
                ks[127-got] = KEYSTREAM_O;
                got++;
            end
            prev_en = CLKEN_I;
            KEY_I = 1'($urandom_range(0, 1));
            IV_I  = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        if (cyc >= 4000) timeout++;
    endtask

    task automatic run_and_check(input string tag, input logic [127:0] key, input logic [95:0] iv,
                                 input logic [127:0] exp);
        logic [127:0] ks;
        int ev, li, he, to;
        run_seq(key, iv, ks, ev, li, he, to);
        check({tag, " keystream"}, ks, exp);
        check({tag, " valid-before-385"}, 128'(ev), 128'd0);
        check({tag, " valid-missing-in-run"}, 128'(li), 128'd0);
        check({tag, " hold-while-disabled"}, 128'(he), 128'd0);
        check({tag, " cycle-budget"}, 128'(to), 128'd0);
    endtask

    // INIT followed by a given number of enabled edges with random data.
    task automatic partial(input int n_edges);
        CLKEN_I = 1'b1;
        INIT_I  = 1'b1;
        tick();
        INIT_I  = 1'b0;
        for (int i = 0; i < n_edges; i++) begin
            KEY_I = 1'($urandom_range(0, 1));
            IV_I  = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    initial begin
        logic [127:0] rk;
        logic [95:0]  riv;
        logic         held_bit;
        int           idle_valid;

        vecs[0] = '{128'h0, 96'h0, 128'hc0207f221660650b6a952ae26586136f};
        vecs[1] = '{128'h0123456789abcdef123456789abcdef0, 96'h0123456789abcdef12345678,
                    128'hf88720c13f46e6a43c07eeed89161a4d};
        vecs[2] = '{128'h0, 96'h800000000000000000000000, 128'h564b362219bd90e301f259cf52bf5da9};
        vecs[3] = '{128'h0123456789abcdef123456789abcdef0, 96'h8123456789abcdef12345678,
                    128'h7f2acdb7adfb701f8d2083b3c32b43f1};

        // Reset state
        ARESET_I = 1'b0;
        CLKEN_I  = 1'b1;
        KEY_I    = 1'b1;
        IV_I     = 1'b1;
        INIT_I   = 1'b0;
        repeat (3) tick();
        check("reset keystream", 128'(KEYSTREAM_O), 128'd0);
        check("reset valid", 128'(KEYSTREAM_VALID_O), 128'd0);
        ARESET_I = 1'b1;
        idle_valid = 0;
        for (int i = 0; i < 20; i++) begin
            CLKEN_I = 1'($urandom_range(0, 1));
            tick();
            if (KEYSTREAM_VALID_O !== 1'b0 || KEYSTREAM_O !== 1'b0) idle_valid++;
        end
        check("idle outputs after reset", 128'(idle_valid), 128'd0);

        // Known-answer vectors, back to back (INIT arrives during RUN).
        for (int v = 0; v < 4; v++) begin
            run_and_check($sformatf("vector%0d", v), vecs[v].key, vecs[v].iv, vecs[v].ks);
            $display("vector %0d applied", v);
        end

        // Explicit hold: CLKEN low keeps the current bit and VALID.
        CLKEN_I  = 1'b0;
        held_bit = KEYSTREAM_O;
        repeat (6) tick();
        check("hold bit with CLKEN=0", 128'(KEYSTREAM_O), 128'(held_bit));
        check("hold valid with CLKEN=0", 128'(KEYSTREAM_VALID_O), 128'd1);

        // Random key/IV against the reference model.
        for (int r = 0; r < 3; r++) begin
            rk  = {$urandom, $urandom, $urandom, $urandom};
            riv = {$urandom, $urandom, $urandom};
            run_and_check($sformatf("random%0d", r), rk, riv, model_ks(rk, riv));
            $display("random %0d applied key=%h iv=%h", r, rk, riv);
        end

        // INIT during LOAD restarts the load cleanly.
        partial(50);
        run_and_check("init-mid-load", vecs[1].key, vecs[1].iv, vecs[1].ks);
        $display("init-mid-load sequence applied");

        // Reset during RUN: VALID drops without waiting for a clock edge.
        check("valid before async reset", 128'(KEYSTREAM_VALID_O), 128'd1);
        #2;
        ARESET_I = 1'b0;
        #1;
        check("valid right after async reset", 128'(KEYSTREAM_VALID_O), 128'd0);
        check("keystream right after async reset", 128'(KEYSTREAM_O), 128'd0);
        tick();
        ARESET_I = 1'b1;

        // Reset during WARMUP, then stay invalid until a new full sequence.
        partial(128 + 100);
        #2;
        ARESET_I = 1'b0;
        #1;
        check("valid after reset mid-warmup", 128'(KEYSTREAM_VALID_O), 128'd0);
        tick();
        ARESET_I = 1'b1;
        idle_valid = 0;
        for (int i = 0; i < 300; i++) begin
            CLKEN_I = 1'b1;
            tick();
            if (KEYSTREAM_VALID_O !== 1'b0) idle_valid++;
        end
        check("invalid after reset until INIT", 128'(idle_valid), 128'd0);
        run_and_check("after-reset vector0", vecs[0].key, vecs[0].iv, vecs[0].ks);
        $display("reset-recovery sequence applied");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
